// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - time-multiplexes one external neuron across a dense layer.
// Optional WAIT timeout with sticky error when LAYER_SEQ_TIMEOUT_EN is defined.
module layer_sequencer #(
   parameter int NUM_INPUTS  = 2,
   parameter int NUM_NEURONS = 4,
   parameter int WIDTH       = 8,
   parameter int IDX_W       = $clog2(NUM_NEURONS) + 1,
   parameter int TIMEOUT     = 255
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [WIDTH*NUM_INPUTS-1:0]  layer_in,
   output logic                         w_rd_en,
   output logic [IDX_W-1:0]             w_addr,
   input  logic [WIDTH*NUM_INPUTS-1:0]  w_data,
   output logic                         n_start,
   output logic [WIDTH*NUM_INPUTS-1:0]  n_weights,
   output logic [WIDTH*NUM_INPUTS-1:0]  n_inputs,
   input  logic [2*WIDTH:0]             n_result,
   input  logic                         n_done,
   output logic                         out_valid,
   output logic [IDX_W-1:0]             out_index,
   output logic [WIDTH-1:0]             out_data,
   output logic [WIDTH*NUM_NEURONS-1:0] layer_out,
   output logic                         busy,
   output logic                         layer_done,
   output logic                         error
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_FIRE, S_WAIT, S_STORE, S_DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

   state_t           state;
   logic [IDX_W-1:0] idx;

   // Only the activated low byte of the neuron result is consumed.
   logic unused_result_bits;
   assign unused_result_bits = ^n_result[2*WIDTH:WIDTH];

`ifdef LAYER_SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wait_cnt;
   logic             error_q;
   assign error = error_q;
`else
   localparam int UNUSED_TIMEOUT = TIMEOUT;
   assign error = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         idx        <= '0;
         w_rd_en    <= 1'b0;
         w_addr     <= '0;
         n_start    <= 1'b0;
         n_weights  <= '0;
         n_inputs   <= '0;
         out_valid  <= 1'b0;
         out_index  <= '0;
         out_data   <= '0;
         layer_out  <= '0;
         busy       <= 1'b0;
         layer_done <= 1'b0;
`ifdef LAYER_SEQ_TIMEOUT_EN
         wait_cnt   <= '0;
         error_q    <= 1'b0;
`endif
      end else begin
         w_rd_en    <= 1'b0;
         n_start    <= 1'b0;
         out_valid  <= 1'b0;
         layer_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  n_inputs <= layer_in;
                  idx      <= '0;
                  w_addr   <= '0;
                  w_rd_en  <= 1'b1;
                  busy     <= 1'b1;
`ifdef LAYER_SEQ_TIMEOUT_EN
                  error_q  <= 1'b0;
`endif
                  state    <= S_FETCH;
               end
            end
            S_FETCH: state <= S_LOAD;
            S_LOAD: begin
               n_weights <= w_data;
               n_start   <= 1'b1;
               state     <= S_FIRE;
            end
            S_FIRE: begin
`ifdef LAYER_SEQ_TIMEOUT_EN
               wait_cnt <= '0;
`endif
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (n_done) begin
                  out_valid <= 1'b1;
                  out_index <= idx;
                  out_data  <= n_result[WIDTH-1:0];
                  for (int i = 0; i < NUM_NEURONS; i++) begin
                     if (idx == IDX_W'(i))
                        layer_out[WIDTH*i +: WIDTH] <= n_result[WIDTH-1:0];
                  end
                  state <= S_STORE;
               end
`ifdef LAYER_SEQ_TIMEOUT_EN
               else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                  // Abandon the whole pass: no result, no layer_done.
                  error_q <= 1'b1;
                  busy    <= 1'b0;
                  state   <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
`endif
            end
            S_STORE: begin
               if (idx == LAST_IDX) begin
                  layer_done <= 1'b1;
                  state      <= S_DONE;
               end else begin
                  idx     <= idx + IDX_W'(1);
                  w_addr  <= idx + IDX_W'(1);
                  w_rd_en <= 1'b1;
                  state   <= S_FETCH;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
